// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: shared immediate-format constants plus the interface
// bundling the instruction-memory channel, redirect and downstream handshake.
package fetch_unit_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned IMM_W  = 25;
  localparam int unsigned CTRL_W = 3;

  localparam logic [CTRL_W-1:0] ITYPE = 3'd0;
  localparam logic [CTRL_W-1:0] STYPE = 3'd1;
  localparam logic [CTRL_W-1:0] BTYPE = 3'd2;
  localparam logic [CTRL_W-1:0] UTYPE = 3'd3;
  localparam logic [CTRL_W-1:0] JTYPE = 3'd4;
endpackage

interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_rsp_valid;
  logic [XLEN-1:0]   imem_rdata;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [XLEN-1:0]   instr;
  logic [XLEN-1:0]   instr_pc;
  logic [IMM_W-1:0]  immed;
  logic [CTRL_W-1:0] imm_ctrl;
  logic              illegal;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
           immed, imm_ctrl, illegal,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, redirect,
           redirect_pc, instr_ready
  );

  // Memory / execute / decode side
  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
           immed, imm_ctrl, illegal,
    output imem_req_ready, imem_rsp_valid, imem_rdata, redirect,
           redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem read, instruction
// register with pre-decoded immediate format, redirect/squash handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic              kill_q;
  logic              req_valid_q;
  logic              instr_valid_q;
  logic [XLEN-1:0]   instr_q;
  logic [XLEN-1:0]   instr_pc_q;
  logic [CTRL_W-1:0] imm_ctrl_q;
  logic              illegal_q;

  logic [XLEN-1:0]   redirect_tgt;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;

  assign redirect_tgt = bus.redirect_pc & ~XLEN'(32'h3);

  // Pre-decode the returning word's opcode into the immediate format
  always_comb begin
    dec_ctrl    = ITYPE;
    dec_illegal = 1'b0;
    unique case (bus.imem_rdata[6:0])
      7'b0010011, 7'b0000011,
      7'b1100111, 7'b1110011: dec_ctrl = ITYPE;
      7'b0100011:             dec_ctrl = STYPE;
      7'b1100011:             dec_ctrl = BTYPE;
      7'b0110111, 7'b0010111: dec_ctrl = UTYPE;
      7'b1101111:             dec_ctrl = JTYPE;
      7'b0110011:             dec_ctrl = ITYPE;
      default:                dec_illegal = 1'b1;
    endcase
  end

  // Fetch FSM: request, wait for response, hold until consumed; redirect wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      imm_ctrl_q    <= ITYPE;
      illegal_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_valid_q && bus.imem_req_ready) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
            if (bus.redirect) begin
              pc_q   <= redirect_tgt;
              kill_q <= 1'b1;
            end
          end else begin
            req_valid_q <= 1'b1;
            if (bus.redirect) pc_q <= redirect_tgt;
          end
        end

        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (kill_q || bus.redirect) begin
              // Squashed response: drop it and refetch from the current PC
              kill_q      <= 1'b0;
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
              if (bus.redirect) pc_q <= redirect_tgt;
            end else begin
              instr_q       <= bus.imem_rdata;
              instr_pc_q    <= pc_q;
              imm_ctrl_q    <= dec_ctrl;
              illegal_q     <= dec_illegal;
              instr_valid_q <= 1'b1;
              state_q       <= S_HOLD;
            end
          end else if (bus.redirect) begin
            pc_q   <= redirect_tgt;
            kill_q <= 1'b1;
          end
        end

        S_HOLD: begin
          if (bus.redirect) begin
            pc_q          <= redirect_tgt;
            instr_valid_q <= 1'b0;
            state_q       <= S_REQ;
            req_valid_q   <= 1'b1;
          end else if (bus.instr_ready) begin
            pc_q          <= pc_q + XLEN'(4);
            instr_valid_q <= 1'b0;
            state_q       <= S_REQ;
            req_valid_q   <= 1'b1;
          end
        end

        default: begin
          state_q     <= S_REQ;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_addr      = pc_q;
  assign bus.instr_valid    = instr_valid_q;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.immed          = instr_q[31:7];
  assign bus.imm_ctrl       = imm_ctrl_q;
  assign bus.illegal        = illegal_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of fetched words with hand-derived formats,
// scoreboard of expected instructions, and redirect/reset corner sequences.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  ctrl;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  ctrl;
    logic        ill;
  } exp_t;

  vec_t        vecs [11];
  exp_t        sbq [$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] model_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) timeout("req_wait");
  endtask

  task automatic accept(input logic [31:0] exp_addr);
    bit ok;
    wait_req(ok);
    check("req_addr", bus.imem_addr, exp_addr);
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    check("req_drop", 32'(bus.imem_req_valid), 32'd0);
  endtask

  task automatic respond(input logic [31:0] pc, input logic [31:0] rdata,
                         input logic [2:0] ctrl, input logic ill, input bit push);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = rdata;
    if (push) sbq.push_back('{pc, rdata, ctrl, ill});
    cyc();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = 32'h0;
  endtask

  task automatic consume();
    bit   ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) timeout("instr_wait");
    else if (sbq.size() == 0) timeout("sb_underflow");
    else begin
      e = sbq.pop_front();
      check("instr",    bus.instr,           e.instr);
      check("instr_pc", bus.instr_pc,        e.pc);
      check("imm_ctrl", 32'(bus.imm_ctrl),   32'(e.ctrl));
      check("illegal",  32'(bus.illegal),    32'(e.ill));
      check("immed",    32'(bus.immed),      e.instr >> 7);
    end
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] rdata, input logic [2:0] ctrl, input logic ill);
    accept(model_pc);
    respond(model_pc, rdata, ctrl, ill, 1'b1);
    consume();
    model_pc = model_pc + 32'd4;
  endtask

  task automatic reset_checks();
    check("rst_req_valid",   32'(bus.imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(bus.instr_valid),    32'd0);
    check("rst_addr",        bus.imem_addr,           32'h0);
    check("rst_instr_pc",    bus.instr_pc,            32'h0);
    check("rst_instr",       bus.instr,               32'h0000_0013);
    check("rst_immed",       32'(bus.immed),          32'h0);
    check("rst_imm_ctrl",    32'(bus.imm_ctrl),       32'(ITYPE));
    check("rst_illegal",     32'(bus.illegal),        32'd0);
  endtask

  initial begin
    bit          ok;
    logic [31:0] snap_instr;
    logic [31:0] snap_pc;

    vecs[0]  = '{32'h0050_0093, ITYPE, 1'b0};
    vecs[1]  = '{32'h0011_2623, STYPE, 1'b0};
    vecs[2]  = '{32'h0000_8463, BTYPE, 1'b0};
    vecs[3]  = '{32'h0008_006F, JTYPE, 1'b0};
    vecs[4]  = '{32'h1234_5037, UTYPE, 1'b0};
    vecs[5]  = '{32'h0000_2003, ITYPE, 1'b0};
    vecs[6]  = '{32'h00B5_0533, ITYPE, 1'b0};
    vecs[7]  = '{32'h0000_1097, UTYPE, 1'b0};
    vecs[8]  = '{32'h0000_8067, ITYPE, 1'b0};
    vecs[9]  = '{32'h0000_0073, ITYPE, 1'b0};
    vecs[10] = '{32'hFFFF_FFFF, ITYPE, 1'b1};

    rst_n               = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rdata      = 32'h0;
    bus.redirect        = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.instr_ready     = 1'b0;

    cyc(); cyc(); cyc();
    reset_checks();
    rst_n    = 1'b1;
    model_pc = 32'h0;

    // Straight-line fetches through the opcode table
    for (int i = 0; i < 11; i++) fetch(vecs[i].rdata, vecs[i].ctrl, vecs[i].ill);

    // Downstream stall: held word stays put, no new request
    accept(model_pc);
    respond(model_pc, 32'h00A0_0513, ITYPE, 1'b0, 1'b1);
    snap_instr = bus.instr;
    snap_pc    = bus.instr_pc;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid",    32'(bus.instr_valid),    32'd1);
      check("stall_instr",    bus.instr,               snap_instr);
      check("stall_pc",       bus.instr_pc,            snap_pc);
      check("stall_no_req",   32'(bus.imem_req_valid), 32'd0);
      cyc();
    end
    consume();
    model_pc = model_pc + 32'd4;

    // Redirect while waiting: late response must be squashed
    accept(model_pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    cyc();
    bus.redirect = 1'b0;
    check("kill_valid0", 32'(bus.instr_valid), 32'd0);
    cyc();
    respond(32'h0, 32'hDEAD_BEEF, ITYPE, 1'b0, 1'b0);
    check("kill_valid1", 32'(bus.instr_valid), 32'd0);
    wait_req(ok);
    check("kill_valid2", 32'(bus.instr_valid), 32'd0);
    check("kill_addr",   bus.imem_addr,        32'h0000_0100);
    model_pc = 32'h0000_0100;
    fetch(32'h0000_0013, ITYPE, 1'b0);

    // Redirect in REQ before accept: address changes, request stays up
    wait_req(ok);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_000A;
    cyc();
    bus.redirect = 1'b0;
    check("reqredir_valid", 32'(bus.imem_req_valid), 32'd1);
    check("reqredir_addr",  bus.imem_addr,           32'h0000_0008);
    model_pc = 32'h0000_0008;

    // Redirect beats instr_ready in HOLD
    accept(model_pc);
    respond(model_pc, 32'h0000_0463, BTYPE, 1'b0, 1'b0);
    check("hold_valid", 32'(bus.instr_valid), 32'd1);
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    cyc();
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    check("holdredir_drop", 32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("backpr_valid", 32'(bus.imem_req_valid), 32'd1);
      check("backpr_addr",  bus.imem_addr,           32'h0000_0040);
      cyc();
    end
    model_pc = 32'h0000_0040;
    fetch(32'h0000_1017, UTYPE, 1'b0);

    // Redirect on the accept cycle: that response is squashed too
    wait_req(ok);
    check("accredir_addr0", bus.imem_addr, 32'h0000_0044);
    bus.imem_req_ready = 1'b1;
    bus.redirect       = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    cyc();
    bus.imem_req_ready = 1'b0;
    bus.redirect       = 1'b0;
    check("accredir_wait", 32'(bus.imem_req_valid), 32'd0);
    cyc();
    respond(32'h0, 32'h1111_1113, ITYPE, 1'b0, 1'b0);
    check("accredir_valid", 32'(bus.instr_valid), 32'd0);
    wait_req(ok);
    check("accredir_addr", bus.imem_addr, 32'h0000_0200);
    model_pc = 32'h0000_0200;
    fetch(32'hFFFF_FFFF, ITYPE, 1'b1);

    // Reset while waiting, then a stale response right after release
    accept(model_pc);
    rst_n = 1'b0;
    cyc(); cyc();
    reset_checks();
    rst_n              = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = 32'hDEAD_BEEF;
    cyc();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = 32'h0;
    check("stale_valid", 32'(bus.instr_valid), 32'd0);
    model_pc = 32'h0;
    fetch(32'h0050_0093, ITYPE, 1'b0);
    wait_req(ok);
    check("post_addr", bus.imem_addr, 32'h0000_0004);

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
